// File: rtl/hilo_ctrl_if.sv
// rtl/hilo_ctrl_if.sv - control-unit and divider/multiplier signal bundle for hilo_ctrl
interface hilo_ctrl_if;
  // Request side from the pipeline control unit
  logic        i_Start;
  logic [1:0]  i_Op;
  logic [31:0] i_A;
  logic [31:0] i_B;
  // Arithmetic unit handshake and results
  logic        w_DivStart;
  logic        w_MultStart;
  logic        w_DivStop;
  logic        w_MultStop;
  logic [31:0] w_DIVHI;
  logic [31:0] w_DIVLO;
  logic [31:0] w_MULTHI;
  logic [31:0] w_MULTLO;
  // Architectural registers and status
  logic [31:0] o_HI;
  logic [31:0] o_LO;
  logic        o_Busy;
  logic        o_Done;
  logic        o_DivZero;
  logic        o_Timeout;

  // Environment side: control unit plus the arithmetic units
  modport master (
    output i_Start, i_Op, i_A, i_B,
    output w_DivStop, w_MultStop, w_DIVHI, w_DIVLO, w_MULTHI, w_MULTLO,
    input  w_DivStart, w_MultStart,
    input  o_HI, o_LO, o_Busy, o_Done, o_DivZero, o_Timeout
  );

  // HI/LO controller side
  modport slave (
    input  i_Start, i_Op, i_A, i_B,
    input  w_DivStop, w_MultStop, w_DIVHI, w_DIVLO, w_MULTHI, w_MULTLO,
    output w_DivStart, w_MultStart,
    output o_HI, o_LO, o_Busy, o_Done, o_DivZero, o_Timeout
  );
endinterface

// File: rtl/hilo_ctrl.sv
// rtl/hilo_ctrl.sv - HI/LO register controller sequencing divider and multiplier runs
module hilo_ctrl #(
  parameter int TIMEOUT = 40
) (
  input  logic        Clock,
  input  logic        Reset,
  hilo_ctrl_if.slave  bus
);

  localparam int CW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_MULT = 2'b01;
  localparam logic [1:0] OP_MTHI = 2'b10;
  localparam logic [1:0] OP_MTLO = 2'b11;

  typedef enum logic [1:0] {IDLE, DIV_RUN, MULT_RUN, DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   hi_q, hi_d;
  logic [31:0]   lo_q, lo_d;
  logic          busy_q, busy_d;
  logic          div_start_q, div_start_d;
  logic          mult_start_q, mult_start_d;
  logic          done_q, done_d;
  logic          divzero_q, divzero_d;
  logic          timeout_q, timeout_d;

  logic          unit_stop;
  logic [31:0]   unit_hi;
  logic [31:0]   unit_lo;

  // Select the stop flag and results of whichever unit is in flight
  always_comb begin
    unit_stop = 1'b0;
    unit_hi   = hi_q;
    unit_lo   = lo_q;
    if (state_q == DIV_RUN) begin
      unit_stop = bus.w_DivStop;
      unit_hi   = bus.w_DIVHI;
      unit_lo   = bus.w_DIVLO;
    end else if (state_q == MULT_RUN) begin
      unit_stop = bus.w_MultStop;
      unit_hi   = bus.w_MULTHI;
      unit_lo   = bus.w_MULTLO;
    end
  end

  // Next-state, counter, HI/LO and status pulse logic
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    hi_d         = hi_q;
    lo_d         = lo_q;
    busy_d       = busy_q;
    div_start_d  = 1'b0;
    mult_start_d = 1'b0;
    done_d       = 1'b0;
    divzero_d    = 1'b0;
    timeout_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.i_Start) begin
          case (bus.i_Op)
            OP_DIV: begin
              if (bus.i_B != 32'd0) begin
                state_d     = DIV_RUN;
                busy_d      = 1'b1;
                div_start_d = 1'b1;
                cnt_d       = '0;
              end else begin
                divzero_d = 1'b1;
              end
            end
            OP_MULT: begin
              state_d      = MULT_RUN;
              busy_d       = 1'b1;
              mult_start_d = 1'b1;
              cnt_d        = '0;
            end
            OP_MTHI: hi_d = bus.i_A;
            OP_MTLO: lo_d = bus.i_A;
            default: ;
          endcase
        end
      end
      DIV_RUN, MULT_RUN: begin
        // cnt_q == 0 is the cycle carrying the start pulse; the unit's stop
        // flag may still be stale then, so it is not trusted until cnt_q > 0.
        if (unit_stop && (cnt_q != '0)) begin
          hi_d    = unit_hi;
          lo_d    = unit_lo;
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          cnt_d   = '0;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          // This run cycle brings the count to TIMEOUT: give up, HI/LO untouched
          state_d   = IDLE;
          busy_d    = 1'b0;
          timeout_d = 1'b1;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset abandons any in-flight operation
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      hi_q         <= '0;
      lo_q         <= '0;
      busy_q       <= 1'b0;
      div_start_q  <= 1'b0;
      mult_start_q <= 1'b0;
      done_q       <= 1'b0;
      divzero_q    <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      hi_q         <= hi_d;
      lo_q         <= lo_d;
      busy_q       <= busy_d;
      div_start_q  <= div_start_d;
      mult_start_q <= mult_start_d;
      done_q       <= done_d;
      divzero_q    <= divzero_d;
      timeout_q    <= timeout_d;
    end
  end

  assign bus.w_DivStart  = div_start_q;
  assign bus.w_MultStart = mult_start_q;
  assign bus.o_HI        = hi_q;
  assign bus.o_LO        = lo_q;
  assign bus.o_Busy      = busy_q;
  assign bus.o_Done      = done_q;
  assign bus.o_DivZero   = divzero_q;
  assign bus.o_Timeout   = timeout_q;

endmodule

// File: tb/tb_hilo_ctrl.sv
// tb/tb_hilo_ctrl.sv - scoreboard bench for hilo_ctrl with divider/multiplier responder
module tb_hilo_ctrl;

  localparam int TMO   = 40;
  localparam int NEVER = 1000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hilo_ctrl_if bus();

  hilo_ctrl #(.TIMEOUT(TMO)) dut (
    .Clock (clk),
    .Reset (rst_n),
    .bus   (bus)
  );

  // kind bits: {done, divzero, timeout}
  typedef struct packed {
    logic [2:0]  kind;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        e;
  int          checks = 0;
  int          failures = 0;
  int          ev_cnt = 0;
  int          div_starts = 0;
  int          mult_starts = 0;
  int          exp_div = 0;
  int          exp_mult = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  int          rsp_lat = 1;
  bit          rsp_stale = 1'b0;
  bit          rsp_busy = 1'b0;
  logic [31:0] cur_a = '0;
  logic [31:0] cur_b = '0;
  logic        prev_ds = 1'b0;
  logic        prev_ms = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Monitor: start-pulse accounting and scoreboard comparison on every status pulse
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_ds = 1'b0;
      prev_ms = 1'b0;
    end else begin
      if (bus.w_DivStart) begin
        div_starts++;
        chk("div_start_width", 64'(prev_ds), 64'd0);
      end
      if (bus.w_MultStart) begin
        mult_starts++;
        chk("mult_start_width", 64'(prev_ms), 64'd0);
      end
      prev_ds = bus.w_DivStart;
      prev_ms = bus.w_MultStart;
      if (bus.o_Done || bus.o_DivZero || bus.o_Timeout) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_event actual=%b required=none", {bus.o_Done, bus.o_DivZero, bus.o_Timeout});
        end else begin
          e = exp_q.pop_front();
          chk("event_kind", 64'({bus.o_Done, bus.o_DivZero, bus.o_Timeout}), 64'(e.kind));
          chk("event_hi", 64'(bus.o_HI), 64'(e.hi));
          chk("event_lo", 64'(bus.o_LO), 64'(e.lo));
          chk("event_busy", 64'(bus.o_Busy), 64'd0);
        end
        ev_cnt++;
      end
    end
  end

  task automatic noise(input bit is_div);
    if (is_div) begin
      bus.w_DivStop  = 1'b0;
      bus.w_MultStop = 1'($urandom_range(0, 1));
      bus.w_MULTHI   = $urandom;
      bus.w_MULTLO   = $urandom;
    end else begin
      bus.w_MultStop = 1'b0;
      bus.w_DivStop  = 1'($urandom_range(0, 1));
      bus.w_DIVHI    = $urandom;
      bus.w_DIVLO    = $urandom;
    end
  endtask

  // Divider/multiplier stand-in: answers a start pulse after rsp_lat cycles
  initial begin : responder
    bit          is_div;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [63:0] prod;
    bus.w_DivStop  = 1'b0;
    bus.w_MultStop = 1'b0;
    bus.w_DIVHI    = '0;
    bus.w_DIVLO    = '0;
    bus.w_MULTHI   = '0;
    bus.w_MULTLO   = '0;
    forever begin
      @(negedge clk);
      bus.w_DivStop  = 1'b0;
      bus.w_MultStop = 1'b0;
      if (rst_n && (bus.w_DivStart || bus.w_MultStart)) begin
        rsp_busy = 1'b1;
        is_div   = bus.w_DivStart;
        if (is_div) begin
          r_hi = cur_a % cur_b;
          r_lo = cur_a / cur_b;
        end else begin
          prod = {32'd0, cur_a} * {32'd0, cur_b};
          r_hi = prod[63:32];
          r_lo = prod[31:0];
        end
        noise(is_div);
        if (rsp_stale) begin
          if (is_div) begin
            bus.w_DivStop = 1'b1;
            bus.w_DIVHI   = $urandom;
            bus.w_DIVLO   = $urandom;
          end else begin
            bus.w_MultStop = 1'b1;
            bus.w_MULTHI   = $urandom;
            bus.w_MULTLO   = $urandom;
          end
        end
        if (rsp_lat < NEVER) begin
          for (int i = 1; i < rsp_lat; i++) begin
            @(negedge clk);
            noise(is_div);
          end
          @(negedge clk);
          noise(is_div);
          if (is_div) begin
            bus.w_DivStop = 1'b1;
            bus.w_DIVHI   = r_hi;
            bus.w_DIVLO   = r_lo;
          end else begin
            bus.w_MultStop = 1'b1;
            bus.w_MULTHI   = r_hi;
            bus.w_MULTLO   = r_lo;
          end
        end
        rsp_busy = 1'b0;
      end
    end
  end

  // Issue one operation, push its expected outcome, and wait for it to drain
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int lat, input bit stale);
    exp_t        x;
    int          ev0;
    int          n;
    bit          runs;
    bit          has_ev;
    logic [63:0] prod;
    cur_a     = a;
    cur_b     = b;
    rsp_lat   = lat;
    rsp_stale = stale;
    runs   = (op == 2'b01) || (op == 2'b00 && b != 0);
    has_ev = (op == 2'b00) || (op == 2'b01);
    if (op == 2'b00 && b == 0) begin
      x = '{kind: 3'b010, hi: m_hi, lo: m_lo};
    end else if (runs && lat + 1 > TMO) begin
      x = '{kind: 3'b001, hi: m_hi, lo: m_lo};
    end else if (op == 2'b00) begin
      m_hi = a % b;
      m_lo = a / b;
      x = '{kind: 3'b100, hi: m_hi, lo: m_lo};
    end else if (op == 2'b01) begin
      prod = {32'd0, a} * {32'd0, b};
      m_hi = prod[63:32];
      m_lo = prod[31:0];
      x = '{kind: 3'b100, hi: m_hi, lo: m_lo};
    end else if (op == 2'b10) begin
      m_hi = a;
    end else begin
      m_lo = a;
    end
    if (has_ev) exp_q.push_back(x);
    if (op == 2'b00 && runs) exp_div++;
    if (op == 2'b01) exp_mult++;
    ev0 = ev_cnt;
    bus.i_Start = 1'b1;
    bus.i_Op    = op;
    bus.i_A     = a;
    bus.i_B     = b;
    step();
    bus.i_Start = 1'b0;
    chk("busy_after_accept", 64'(bus.o_Busy), 64'(runs));
    if (!has_ev) begin
      chk("mt_hi", 64'(bus.o_HI), 64'(m_hi));
      chk("mt_lo", 64'(bus.o_LO), 64'(m_lo));
    end else begin
      n = 0;
      while (ev_cnt == ev0 && n < 200) begin
        bus.i_Start = 1'b0;
        if (bus.o_Busy && $urandom_range(0, 3) == 0) begin
          bus.i_Start = 1'b1;
          bus.i_Op    = 2'($urandom_range(0, 3));
          bus.i_A     = $urandom;
          bus.i_B     = $urandom;
        end
        step();
        n++;
      end
      bus.i_Start = 1'b0;
      chk("event_count", 64'(ev_cnt - ev0), 64'd1);
      n = 0;
      while (rsp_busy && n < 200) begin
        step();
        n++;
      end
      chk("responder_idle", 64'(rsp_busy), 64'd0);
    end
    step();
  endtask

  initial begin : driver
    int ev0;
    int n;
    bus.i_Start = 1'b0;
    bus.i_Op    = 2'b00;
    bus.i_A     = '0;
    bus.i_B     = '0;
    repeat (3) step();
    rst_n = 1'b1;
    step();
    chk("rst_hi", 64'(bus.o_HI), 64'd0);
    chk("rst_lo", 64'(bus.o_LO), 64'd0);
    chk("rst_busy", 64'(bus.o_Busy), 64'd0);
    chk("rst_pulses", 64'({bus.o_Done, bus.o_DivZero, bus.o_Timeout, bus.w_DivStart, bus.w_MultStart}), 64'd0);

    // Directed cases
    run_op(2'b00, 32'd7, 32'd3, 33, 1'b0);
    run_op(2'b00, 32'd99, 32'd0, 1, 1'b0);
    run_op(2'b10, 32'hDEADBEEF, 32'd0, 1, 1'b0);
    run_op(2'b11, 32'h12345678, 32'd0, 1, 1'b0);
    run_op(2'b01, 32'h00010003, 32'h00020005, NEVER, 1'b1);
    run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, TMO - 1, 1'b1);
    run_op(2'b00, 32'h80000001, 32'd10, TMO, 1'b0);
    run_op(2'b00, 32'd1000, 32'd7, 1, 1'b1);

    // Randomised mix
    for (int k = 0; k < 40; k++) begin
      logic [1:0]  op;
      logic [31:0] b;
      op = 2'($urandom_range(0, 3));
      b  = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
      run_op(op, $urandom, b, $urandom_range(1, 45), 1'($urandom_range(0, 1)));
    end

    // Reset in the middle of a divide; the late stop must be discarded
    run_op(2'b10, 32'hA5A5A5A5, 32'd0, 1, 1'b0);
    cur_a     = 32'd500;
    cur_b     = 32'd9;
    rsp_lat   = 20;
    rsp_stale = 1'b0;
    bus.i_Start = 1'b1;
    bus.i_Op    = 2'b00;
    bus.i_A     = 32'd500;
    bus.i_B     = 32'd9;
    exp_div++;
    step();
    bus.i_Start = 1'b0;
    repeat (5) step();
    rst_n = 1'b0;
    #1;
    chk("async_rst_hi", 64'(bus.o_HI), 64'd0);
    chk("async_rst_busy", 64'(bus.o_Busy), 64'd0);
    step();
    rst_n = 1'b1;
    m_hi = '0;
    m_lo = '0;
    exp_q.delete();
    ev0 = ev_cnt;
    n = 0;
    while (rsp_busy && n < 200) begin
      step();
      n++;
    end
    repeat (2) step();
    chk("no_event_after_reset", 64'(ev_cnt - ev0), 64'd0);
    chk("post_rst_hi", 64'(bus.o_HI), 64'd0);
    chk("post_rst_lo", 64'(bus.o_LO), 64'd0);
    run_op(2'b00, 32'd500, 32'd9, 5, 1'b0);

    chk("div_start_count", 64'(div_starts), 64'(exp_div));
    chk("mult_start_count", 64'(mult_starts), 64'(exp_mult));
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hilo_ctrl.md
HILO_CTRL -- requirements
Module: hilo_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 40, the maximum cycles to wait for unit completion.
REQ-002 SHALL have Clock  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have Reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 SHALL have i_Start  input  1  one-cycle request from control unit.
REQ-005 SHALL have i_Op  input  2  00 DIV, 01 MULT, 10 MTHI, 11 MTLO; sampled with i_Start.
REQ-006 SHALL have i_A, i_B  input  32 each  operands; i_B is divisor for DIV; i_A is data for MTHI/MTLO.
REQ-007 SHALL have w_DivStart, w_MultStart  output  1 each  one-cycle start pulses to divider/multiplier.
REQ-008 SHALL have w_DivStop, w_MultStop  input  1 each  completion flags from the units.
REQ-009 SHALL have w_DIVHI, w_DIVLO, w_MULTHI, w_MULTLO  input  32 each  unit results.
REQ-010 SHALL have o_HI, o_LO  output  32 each  architectural HI/LO registers.
REQ-011 SHALL have o_Busy  output  1  high while a DIV/MULT is in flight (pipeline stall).
REQ-012 SHALL have o_Done, o_DivZero, o_Timeout  output  1 each  one-cycle status pulses.

Function
REQ-013 SHALL implement FSM states IDLE, DIV_RUN, MULT_RUN, DONE.
REQ-014 IDLE + i_Start + DIV + i_B!=0: SHALL pulse w_DivStart next cycle, enter DIV_RUN, clear cycle counter.
REQ-015 IDLE + i_Start + DIV + i_B==0: SHALL not start divider, pulse o_DivZero one cycle, keep HI/LO, stay IDLE.
REQ-016 IDLE + i_Start + MULT: SHALL pulse w_MultStart next cycle, enter MULT_RUN, clear counter.
REQ-017 IDLE + i_Start + MTHI/MTLO: SHALL write i_A into o_HI/o_LO on that edge, no busy, no o_Done.
REQ-018 o_Busy SHALL rise on the edge that accepts DIV/MULT and stay high through DIV_RUN/MULT_RUN.
REQ-019 Start pulses SHALL be exactly one cycle; operands held by caller are not re-sampled by this block.
REQ-020 w_DivStop/w_MultStop SHALL be ignored for the first cycle after the start pulse (unit clears stale stop).
REQ-021 DIV_RUN + w_DivStop: SHALL latch w_DIVHI->o_HI, w_DIVLO->o_LO, enter DONE.
REQ-022 MULT_RUN + w_MultStop: SHALL latch w_MULTHI->o_HI, w_MULTLO->o_LO, enter DONE.
REQ-023 DONE: SHALL pulse o_Done, drop o_Busy, return to IDLE next cycle.
REQ-024 Counter SHALL increment each RUN cycle; reaching TIMEOUT without stop SHALL pulse o_Timeout, keep HI/LO, return IDLE, drop o_Busy.
REQ-025 i_Start while not IDLE SHALL be ignored (no queueing).
REQ-026 Stop flag of the unit not in flight SHALL be ignored.
REQ-027 Stop and timeout on same cycle: stop SHALL win (results latched, no o_Timeout).
REQ-028 Counter width SHALL be ceil(log2(TIMEOUT+1)) bits and never wrap.

Reset
REQ-029 Reset low SHALL immediately force IDLE, o_HI=o_LO=0, counter=0, all pulses and o_Busy low, regardless of in-flight op.
REQ-030 Reset mid-operation SHALL discard any later unit stop; first post-reset i_Start SHALL be accepted normally.

Verification
REQ-031 Reset low then high -> o_HI=o_LO=0, o_Busy=0, state IDLE.
REQ-032 DIV i_B=3, divider returns HI=1, LO=2 after 33 cycles -> w_DivStart one pulse, o_Busy high until latch, o_HI=1, o_LO=2, o_Done one pulse.
REQ-033 DIV i_B=0 -> o_DivZero one pulse, w_DivStart never asserted, HI/LO unchanged.
REQ-034 MTHI i_A=0xDEADBEEF then MTLO i_A=0x12345678 -> o_HI=0xDEADBEEF, o_LO=0x12345678, o_Busy never high.
REQ-035 MULT with w_MultStop never asserted -> o_Timeout pulse after 40 run cycles, o_Busy low, HI/LO unchanged; i_Start during run ignored.
REQ-036 Reset low mid DIV_RUN, then w_DivStop -> HI/LO remain 0, no o_Done.
